alu_lanes_pipe: RTL and testbench
=================================

Name: alu_lanes_pipe

Overview:
Parametrised, registered successor to the 6-lane vector ALU stage. It has LANES identical N-bit lanes with a per-lane enable mask and a valid/ready handshake on both input and output. It also adds a sequential cross-lane sum-reduction mode that writes its result to lane 0. It sits in the vector execute stage, between the register-read/forwarding muxes and the memory/writeback pipeline registers.

Parameters:
N, 8, lane data width in bits (>=4)
LANES, 6, number of vector lanes (>=2)
IW, $clog2(LANES), width of the broadcast lane index

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operand bundle valid
in_ready  out  1  block can accept a bundle this cycle
SrcAE  in  [LANES][N]  operand A per lane
SrcBE  in  [LANES][N]  operand B per lane
SrcBiE  in  IW  lane index used for broadcast mode
ImmE  in  N  immediate operand
ALUControlE  in  3  operation select
VSIFlagE  in  2  B source: 00 per-lane SrcBE[i], 01 broadcast SrcBE[SrcBiE], 1x ImmE
LaneMaskE  in  LANES  1 = lane active
ReduceE  in  1  1 = sum active-lane results into lane 0
out_valid  out  1  result registers valid
out_ready  in  1  downstream accepts the result
ALUOutputE  out  [LANES][N]  registered lane results
ALUFlagsE  out  [LANES][2]  registered per-lane flags {Neg, Zero}

Behaviour:
- Reset (async, any state): state=IDLE; out_valid=0; ALUOutputE=0; ALUFlagsE=0; accumulator and index cleared. Any in-flight op is dropped. in_ready=1 once reset deasserts.
- Accept: accept = in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Same-cycle drain-and-refill is allowed.
- B select:
  - SrcBiE >= LANES selects lane 0.
  - VSIFlagE 10 and 11 both select ImmE.
- Ops (B = selected operand, all results mod 2^N):
  - 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A^B
  - 101 A<<B[log2(N)-1:0]
  - 110 A>>B[log2(N)-1:0] (logical)
  - 111 low N bits of A*B
- Flags per lane: Neg = result[N-1]; Zero = (result==0).
- Masked lanes (LaneMaskE[i]=0): output 0, flags 00. They are excluded from reduction.
- Elementwise (ReduceE=0): accept at cycle t. ALUOutputE, ALUFlagsE and out_valid are updated at edge t+1. Latency 1. Full throughput of 1 bundle/cycle while out_ready=1.
- Output hold: while out_valid && !out_ready, outputs hold stable and in_ready=0.
- Reduction (ReduceE=1), FSM IDLE -> RED -> IDLE:
  - On accept: latch the masked per-lane results into an internal buffer; acc=0; idx=0; state=RED. out_valid falls if the old result is consumed that cycle.
  - RED: each cycle acc += buf[idx] (N-bit, wraps); idx++. After the idx==LANES-1 cycle: lane 0 = acc, flags from acc; lanes 1..LANES-1 = 0, flags 00; out_valid=1; state=IDLE.
  - Latency: accept at t -> out_valid at edge t+LANES+1.
  - in_ready=0 throughout RED.
  - All-lanes-masked reduction yields 0 with flags 01.
- in_valid and the operand ports are ignored when not accepted.
- No combinational path from any input to ALUOutputE or ALUFlagsE.

Test Plan:
- Reset mid-reduction: assert reset 2 cycles into RED with LANES=6 -> out_valid=0, all outputs 0 immediately (async); in_ready=1 after release.
- Elementwise ADD, VSIFlag=00, A[i]=i+1, B[i]=0xFF, N=8, mask all-ones -> at t+1, lane0=0x00 flags 01; lanes1..5 = i, flags 00.
- Broadcast SUB, VSIFlag=01, SrcBiE=3, B[3]=5, A all 3 -> every lane 0xFE, flags 10. Repeat with SrcBiE=7 and B[0]=1 -> every lane 0x02, flags 00.
- Imm MUL with mask 6'b101010: ImmE=0x10, A=0x11 -> odd lanes 0x10, even lanes 0 with flags 00.
- Reduction: ADD with ImmE=0, A={0x80,0x80,1,2,3,4}, mask all-ones -> in_ready low 6 cycles; out_valid at t+7; lane0=0x0A (wrap), flags 00; other lanes 0.
- Backpressure: stream 4 ADD bundles with out_ready toggling 1,0,0,1 -> no bundle lost or duplicated; outputs stable while stalled; in_ready=0 exactly on stalled cycles.

Source files
------------

// File: rtl/alu_lanes_pipe.sv
// alu_lanes_pipe: registered LANES-wide vector ALU with per-lane enable mask,
// valid/ready handshake on both sides and a sequential sum-reduction mode
// that folds the active-lane results into lane 0.
module alu_lanes_pipe #(
  parameter int N     = 8,
  parameter int LANES = 6,
  parameter int IW    = $clog2(LANES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES-1:0][N-1:0]   SrcAE,
  input  logic [LANES-1:0][N-1:0]   SrcBE,
  input  logic [IW-1:0]             SrcBiE,
  input  logic [N-1:0]              ImmE,
  input  logic [2:0]                ALUControlE,
  input  logic [1:0]                VSIFlagE,
  input  logic [LANES-1:0]          LaneMaskE,
  input  logic                      ReduceE,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES-1:0][N-1:0]   ALUOutputE,
  output logic [LANES-1:0][1:0]     ALUFlagsE
);

  // Shift amounts only use the low log2(N) bits of the B operand.
  localparam int SW = $clog2(N);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RED  = 1'b1
  } state_t;

  state_t                    state_r;
  logic                      out_valid_r;
  logic [LANES-1:0][N-1:0]   out_r;
  logic [LANES-1:0][1:0]     flags_r;
  logic [LANES-1:0][N-1:0]   buf_r;
  logic [N-1:0]              acc_r;
  logic [IW-1:0]             idx_r;

  logic                      accept_s;
  logic [IW-1:0]             bsel_idx_s;
  logic [N-1:0]              bcast_s;
  logic [LANES-1:0][N-1:0]   res_s;
  logic [LANES-1:0][1:0]     flags_s;
  logic [N-1:0]              acc_next_s;
  logic                      red_last_s;
  logic [LANES-1:0][N-1:0]   red_out_s;
  logic [LANES-1:0][1:0]     red_flags_s;

  // Single-lane operation; all results wrap to N bits.
  function automatic logic [N-1:0] lane_op(input logic [N-1:0] a,
                                           input logic [N-1:0] b,
                                           input logic [2:0]   op);
    logic [N-1:0] r;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      3'b101:  r = a << b[SW-1:0];
      3'b110:  r = a >> b[SW-1:0];
      3'b111:  r = a * b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // {Neg, Zero} flags of a lane result.
  function automatic logic [1:0] lane_flags(input logic [N-1:0] r);
    return {r[N-1], (r == '0)};
  endfunction

  assign accept_s   = in_valid && in_ready;
  assign in_ready   = (state_r == IDLE) && (!out_valid_r || out_ready);
  assign out_valid  = out_valid_r;
  assign ALUOutputE = out_r;
  assign ALUFlagsE  = flags_r;

  // Broadcast lane pick; an out-of-range index falls back to lane 0.
  always_comb begin
    bsel_idx_s = '0;
    if (int'(SrcBiE) < LANES) begin
      bsel_idx_s = SrcBiE;
    end else begin
      bsel_idx_s = '0;
    end
    bcast_s = SrcBE[bsel_idx_s];
  end

  // Per-lane B select, operation and masking.
  always_comb begin
    res_s   = '0;
    flags_s = '0;
    for (int i = 0; i < LANES; i++) begin
      logic [N-1:0] b;
      if (VSIFlagE[1]) begin
        b = ImmE;
      end else if (VSIFlagE[0]) begin
        b = bcast_s;
      end else begin
        b = SrcBE[i];
      end
      if (LaneMaskE[i]) begin
        res_s[i]   = lane_op(SrcAE[i], b, ALUControlE);
        flags_s[i] = lane_flags(res_s[i]);
      end else begin
        res_s[i]   = '0;
        flags_s[i] = 2'b00;
      end
    end
  end

  // Reduction step: next accumulator and the final lane-0-only result.
  always_comb begin
    acc_next_s     = acc_r + buf_r[idx_r];
    red_last_s     = (idx_r == IW'(LANES - 1));
    red_out_s      = '0;
    red_flags_s    = '0;
    red_out_s[0]   = acc_next_s;
    red_flags_s[0] = lane_flags(acc_next_s);
  end

  // Handshake FSM, reduction datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      out_r       <= '0;
      flags_r     <= '0;
      buf_r       <= '0;
      acc_r       <= '0;
      idx_r       <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (ReduceE) begin
              buf_r       <= res_s;
              acc_r       <= '0;
              idx_r       <= '0;
              out_valid_r <= 1'b0;
              state_r     <= RED;
            end else begin
              out_r       <= res_s;
              flags_r     <= flags_s;
              out_valid_r <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        RED: begin
          acc_r <= acc_next_s;
          if (red_last_s) begin
            out_r       <= red_out_s;
            flags_r     <= red_flags_s;
            out_valid_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_lanes_pipe.sv
// Self-checking bench for alu_lanes_pipe: directed cases followed by a
// randomized stream with random backpressure, checked against a
// transaction-level model of accepted bundles and produced results.
module tb_alu_lanes_pipe;

  localparam int N     = 8;
  localparam int LANES = 6;
  localparam int IW    = $clog2(LANES);
  localparam int M     = 1 << N;

  logic                     clk;
  logic                     reset;
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES-1:0][N-1:0]  SrcAE;
  logic [LANES-1:0][N-1:0]  SrcBE;
  logic [IW-1:0]            SrcBiE;
  logic [N-1:0]             ImmE;
  logic [2:0]               ALUControlE;
  logic [1:0]               VSIFlagE;
  logic [LANES-1:0]         LaneMaskE;
  logic                     ReduceE;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES-1:0][N-1:0]  ALUOutputE;
  logic [LANES-1:0][1:0]    ALUFlagsE;

  int n_checks = 0;
  int n_errors = 0;

  alu_lanes_pipe #(.N(N), .LANES(LANES)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .SrcBiE(SrcBiE), .ImmE(ImmE),
    .ALUControlE(ALUControlE), .VSIFlagE(VSIFlagE), .LaneMaskE(LaneMaskE),
    .ReduceE(ReduceE), .out_valid(out_valid), .out_ready(out_ready),
    .ALUOutputE(ALUOutputE), .ALUFlagsE(ALUFlagsE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_op(input int a, input int b, input int op);
    case (op)
      0: return (a + b) % M;
      1: return (a - b + M) % M;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (a << (b % N)) % M;
      6: return a >> (b % N);
      7: return (a * b) % M;
      default: return 0;
    endcase
  endfunction

  function automatic int ref_flags(input int v);
    return (((v >> (N - 1)) & 1) * 2) + ((v == 0) ? 1 : 0);
  endfunction

  int held_v[LANES], held_f[LANES];
  int pend_v[LANES], pend_f[LANES];
  int nxt_v[LANES],  nxt_f[LANES];
  int red_sum;
  bit mv = 1'b0;
  int busy = 0;

  // Expected result of the bundle currently on the input ports.
  task automatic model_bundle();
    int bsrc;
    int bv;
    bsrc = (int'(SrcBiE) < LANES) ? int'(SrcBiE) : 0;
    red_sum = 0;
    for (int i = 0; i < LANES; i++) begin
      if (VSIFlagE[1]) bv = int'(ImmE);
      else if (VSIFlagE[0]) bv = int'(SrcBE[bsrc]);
      else bv = int'(SrcBE[i]);
      if (LaneMaskE[i]) begin
        nxt_v[i] = ref_op(int'(SrcAE[i]), bv, int'(ALUControlE));
        nxt_f[i] = ref_flags(nxt_v[i]);
        red_sum  = (red_sum + nxt_v[i]) % M;
      end else begin
        nxt_v[i] = 0;
        nxt_f[i] = 0;
      end
    end
  endtask

  // Cycle monitor: compare visible outputs, then advance the model.
  always @(negedge clk) begin
    bit exp_rdy;
    if (reset) begin
      mv   = 1'b0;
      busy = 0;
    end else begin
      check_value("out_valid", 64'(out_valid), 64'(mv));
      if (mv) begin
        for (int i = 0; i < LANES; i++) begin
          check_value($sformatf("lane%0d_out", i), 64'(ALUOutputE[i]), 64'(held_v[i]));
          check_value($sformatf("lane%0d_flags", i), 64'(ALUFlagsE[i]), 64'(held_f[i]));
        end
      end
      exp_rdy = (busy == 0) && (!mv || out_ready);
      check_value("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          mv = 1'b1;
          held_v = pend_v;
          held_f = pend_f;
        end
      end else begin
        if (mv && out_ready) mv = 1'b0;
        if (in_valid && exp_rdy) begin
          model_bundle();
          if (ReduceE) begin
            for (int i = 0; i < LANES; i++) begin
              pend_v[i] = 0;
              pend_f[i] = 0;
            end
            pend_v[0] = red_sum;
            pend_f[0] = ref_flags(red_sum);
            busy = LANES;
            mv = 1'b0;
          end else begin
            held_v = nxt_v;
            held_f = nxt_f;
            mv = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [LANES-1:0][N-1:0] a, input logic [LANES-1:0][N-1:0] b,
                      input int bi, input int imm, input int op, input int vsi,
                      input int mask, input int red);
    bit ok;
    SrcAE       = a;
    SrcBE       = b;
    SrcBiE      = IW'(bi);
    ImmE        = N'(imm);
    ALUControlE = 3'(op);
    VSIFlagE    = 2'(vsi);
    LaneMaskE   = LANES'(mask);
    ReduceE     = red[0];
    in_valid    = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_value("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  logic [LANES-1:0][N-1:0] ra, rb;
  bit rand_done;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    SrcAE = '0; SrcBE = '0; SrcBiE = '0; ImmE = '0;
    ALUControlE = 3'd0; VSIFlagE = 2'd0; LaneMaskE = '0; ReduceE = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_out_valid", 64'(out_valid), 64'd0);
    check_value("rst_out", 64'(ALUOutputE), 64'd0);
    check_value("rst_flags", 64'(ALUFlagsE), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check_value("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Elementwise ADD, per-lane B = 0xFF.
    for (int i = 0; i < LANES; i++) begin ra[i] = N'(i + 1); rb[i] = 8'hFF; end
    send(ra, rb, 0, 0, 0, 0, 6'h3F, 0);
    check_value("add_lane0", 64'(ALUOutputE[0]), 64'h00);
    check_value("add_flags0", 64'(ALUFlagsE[0]), 64'd1);
    for (int i = 1; i < LANES; i++) begin
      check_value("add_lane", 64'(ALUOutputE[i]), 64'(i));
      check_value("add_flags", 64'(ALUFlagsE[i]), 64'd0);
    end

    // Broadcast SUB from lane 3, then out-of-range index falling back to lane 0.
    for (int i = 0; i < LANES; i++) begin ra[i] = 8'h03; rb[i] = N'($urandom); end
    rb[3] = 8'h05;
    send(ra, rb, 3, 0, 1, 1, 6'h3F, 0);
    for (int i = 0; i < LANES; i++) begin
      check_value("bsub_lane", 64'(ALUOutputE[i]), 64'hFE);
      check_value("bsub_flags", 64'(ALUFlagsE[i]), 64'd2);
    end
    rb[0] = 8'h01;
    send(ra, rb, 7, 0, 1, 1, 6'h3F, 0);
    for (int i = 0; i < LANES; i++) begin
      check_value("bsub7_lane", 64'(ALUOutputE[i]), 64'h02);
      check_value("bsub7_flags", 64'(ALUFlagsE[i]), 64'd0);
    end

    // Immediate MUL with a sparse mask.
    for (int i = 0; i < LANES; i++) ra[i] = 8'h11;
    send(ra, rb, 0, 8'h10, 7, 2, 6'b101010, 0);
    for (int i = 0; i < LANES; i++) begin
      check_value("mul_lane", 64'(ALUOutputE[i]), (i % 2 == 1) ? 64'h10 : 64'h00);
      check_value("mul_flags", 64'(ALUFlagsE[i]), 64'd0);
    end

    // Reduction of ADD with imm 0; sum wraps to 0x0A.
    ra[0] = 8'h04; ra[1] = 8'h03; ra[2] = 8'h02; ra[3] = 8'h01; ra[4] = 8'h80; ra[5] = 8'h80;
    send(ra, rb, 0, 0, 0, 2, 6'h3F, 1);
    repeat (6) @(posedge clk);
    #1;
    check_value("red_valid", 64'(out_valid), 64'd1);
    check_value("red_lane0", 64'(ALUOutputE[0]), 64'h0A);
    check_value("red_flags0", 64'(ALUFlagsE[0]), 64'd0);
    for (int i = 1; i < LANES; i++) check_value("red_lane", 64'(ALUOutputE[i]), 64'd0);

    // All-masked reduction gives zero with the Zero flag set.
    send(ra, rb, 0, 0, 0, 2, 0, 1);
    repeat (6) @(posedge clk);
    #1;
    check_value("red0_lane0", 64'(ALUOutputE[0]), 64'h00);
    check_value("red0_flags0", 64'(ALUFlagsE[0]), 64'd1);

    // Elementwise bundle so outputs are non-zero, then reset mid-reduction.
    for (int i = 0; i < LANES; i++) begin ra[i] = 8'h41; rb[i] = 8'h01; end
    send(ra, rb, 0, 0, 0, 0, 6'h3F, 0);
    send(ra, rb, 0, 0, 0, 0, 6'h3F, 1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check_value("amid_out_valid", 64'(out_valid), 64'd0);
    check_value("amid_out", 64'(ALUOutputE), 64'd0);
    check_value("amid_flags", 64'(ALUFlagsE), 64'd0);
    @(posedge clk); #3;
    reset = 1'b0;
    @(negedge clk);
    check_value("amid_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Backpressure: four ADD bundles while out_ready cycles 1,0,0,1.
    fork
      begin
        for (int n = 0; n < 4; n++) begin
          for (int i = 0; i < LANES; i++) begin ra[i] = N'($urandom); rb[i] = N'($urandom); end
          send(ra, rb, 0, 0, 0, 0, 6'h3F, 0);
        end
      end
      begin
        for (int c = 0; c < 16; c++) begin
          out_ready = (c % 4 == 0) || (c % 4 == 3);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk); #1;

    // Randomized stream with random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          for (int i = 0; i < LANES; i++) begin ra[i] = N'($urandom); rb[i] = N'($urandom); end
          send(ra, rb, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 63)), ($urandom_range(0, 5) == 0) ? 1 : 0);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (20) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
